// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The slave modport is the unit itself; the master modport is the
// environment (execute stage, response consumer and attached memory).
interface load_store_unit_if #(
    parameter int XLEN   = 32,
    parameter int LS_SEL = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [LS_SEL:0]   load_store_type;
    logic [XLEN-1:0]   base;
    logic [XLEN-1:0]   offset;
    logic [XLEN-1:0]   store_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic              resp_error;
    logic [1:0]        resp_cause;
    logic [XLEN-1:0]   resp_addr;
    logic              mem_write_enable;
    logic [LS_SEL:0]   mem_load_store_type;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_data;
    logic [XLEN-1:0]   mem_read_data;

    modport slave (
        input  req_valid, load_store_type, base, offset, store_data,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_data, resp_error, resp_cause, resp_addr,
        output mem_write_enable, mem_load_store_type, mem_addr, mem_data
    );

    modport master (
        output req_valid, load_store_type, base, offset, store_data,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_data, resp_error, resp_cause, resp_addr,
        input  mem_write_enable, mem_load_store_type, mem_addr, mem_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, computes the effective
// address, checks type/alignment/range, drives the byte-addressed data memory
// (1-cycle registered read) and returns the result on a valid/ready channel.
// Type encoding: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW, 8-15 illegal.
module load_store_unit #(
    parameter int MEMORY_DEPTH = 1024,
    parameter int XLEN         = 32
) (
    input logic              i_Clock,
    input logic              i_Reset_N,
    load_store_unit_if.slave bus
);
    localparam int LS_SEL = 3;
    localparam int EW     = XLEN + 1;

    localparam logic [LS_SEL:0] LS_TYPE_LB  = 4'd0;
    localparam logic [LS_SEL:0] LS_TYPE_LH  = 4'd1;
    localparam logic [LS_SEL:0] LS_TYPE_LW  = 4'd2;
    localparam logic [LS_SEL:0] LS_TYPE_LBU = 4'd3;
    localparam logic [LS_SEL:0] LS_TYPE_LHU = 4'd4;
    localparam logic [LS_SEL:0] LS_TYPE_SB  = 4'd5;
    localparam logic [LS_SEL:0] LS_TYPE_SH  = 4'd6;
    localparam logic [LS_SEL:0] LS_TYPE_SW  = 4'd7;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] CAUSE_RANGE      = 2'd2;
    localparam logic [1:0] CAUSE_ILLEGAL    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STORE   = 3'd1,
        ST_LD_ADDR = 3'd2,
        ST_LD_DATA = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] ea_r;
    logic [XLEN-1:0] data_r;
    logic [XLEN-1:0] resp_data_r;
    logic [LS_SEL:0] type_r;
    logic            error_r;
    logic [1:0]      cause_r;

    logic [XLEN-1:0] ea_s;
    logic [2:0]      size_s;
    logic            legal_s;
    logic            is_store_s;
    logic            misaligned_s;
    logic            out_of_range_s;
    logic [EW-1:0]   end_s;
    logic [1:0]      cause_s;

    // Effective address and access size / direction decoded from the type.
    always_comb begin
        ea_s       = bus.base + bus.offset;
        legal_s    = 1'b1;
        is_store_s = 1'b0;
        size_s     = 3'd4;
        case (bus.load_store_type)
            LS_TYPE_LB, LS_TYPE_LBU: size_s = 3'd1;
            LS_TYPE_LH, LS_TYPE_LHU: size_s = 3'd2;
            LS_TYPE_LW:              size_s = 3'd4;
            LS_TYPE_SB: begin
                size_s     = 3'd1;
                is_store_s = 1'b1;
            end
            LS_TYPE_SH: begin
                size_s     = 3'd2;
                is_store_s = 1'b1;
            end
            LS_TYPE_SW: begin
                size_s     = 3'd4;
                is_store_s = 1'b1;
            end
            default: begin
                legal_s = 1'b0;
                size_s  = 3'd1;
            end
        endcase
    end

    // Fault classification; the range end is computed one bit wider so a
    // high effective address cannot wrap back into range.
    always_comb begin
        misaligned_s   = ((size_s == 3'd2) && ea_s[0]) ||
                         ((size_s == 3'd4) && (ea_s[1:0] != 2'b00));
        end_s          = {1'b0, ea_s} + EW'(size_s);
        out_of_range_s = end_s > EW'(MEMORY_DEPTH);
        if (!legal_s) begin
            cause_s = CAUSE_ILLEGAL;
        end else if (misaligned_s) begin
            cause_s = CAUSE_MISALIGNED;
        end else if (out_of_range_s) begin
            cause_s = CAUSE_RANGE;
        end else begin
            cause_s = CAUSE_NONE;
        end
    end

    // Request sequencer: latches the request, walks the memory access and
    // holds the response until it is consumed.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            state_r     <= ST_IDLE;
            ea_r        <= '0;
            data_r      <= '0;
            resp_data_r <= '0;
            type_r      <= '0;
            error_r     <= 1'b0;
            cause_r     <= CAUSE_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        ea_r        <= ea_s;
                        type_r      <= bus.load_store_type;
                        data_r      <= bus.store_data;
                        resp_data_r <= '0;
                        cause_r     <= cause_s;
                        error_r     <= (cause_s != CAUSE_NONE);
                        if (cause_s != CAUSE_NONE) begin
                            state_r <= ST_RESP;
                        end else if (is_store_s) begin
                            state_r <= ST_STORE;
                        end else begin
                            state_r <= ST_LD_ADDR;
                        end
                    end
                end
                ST_STORE:   state_r <= ST_RESP;
                ST_LD_ADDR: state_r <= ST_LD_DATA;
                ST_LD_DATA: begin
                    resp_data_r <= bus.mem_read_data;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready           = (state_r == ST_IDLE);
    assign bus.resp_valid          = (state_r == ST_RESP);
    assign bus.mem_write_enable    = (state_r == ST_STORE);
    assign bus.resp_data           = resp_data_r;
    assign bus.resp_error          = error_r;
    assign bus.resp_cause          = cause_r;
    assign bus.resp_addr           = ea_r;
    assign bus.mem_addr            = ea_r;
    assign bus.mem_load_store_type = type_r;
    assign bus.mem_data            = data_r;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a reference model computes the
// expected response when each request is driven; the response observed on
// the bus is popped against it. A byte memory model with a registered read
// is attached to the memory port.
module tb_load_store_unit;
    localparam int DEPTH = 1024;

    localparam logic [3:0] T_LB  = 4'd0;
    localparam logic [3:0] T_LH  = 4'd1;
    localparam logic [3:0] T_LW  = 4'd2;
    localparam logic [3:0] T_LBU = 4'd3;
    localparam logic [3:0] T_LHU = 4'd4;
    localparam logic [3:0] T_SB  = 4'd5;
    localparam logic [3:0] T_SH  = 4'd6;
    localparam logic [3:0] T_SW  = 4'd7;
    localparam logic [3:0] T_BAD = 4'd12;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [1:0]  cause;
        logic [31:0] addr;
        logic [3:0]  lat;
        logic        we;
    } resp_t;

    typedef struct packed {
        logic [3:0]  t;
        logic [31:0] b;
        logic [31:0] o;
        logic [31:0] d;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    resp_t exp_q[$];

    load_store_unit_if #(.XLEN(32), .LS_SEL(3)) bus ();

    load_store_unit #(.MEMORY_DEPTH(DEPTH), .XLEN(32)) dut (
        .i_Clock   (clk),
        .i_Reset_N (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- attached memory model ----------------
    logic [7:0]  mem [0:DEPTH-1] = '{default: 8'h00};
    logic [7:0]  ref_mem [0:DEPTH-1] = '{default: 8'h00};
    logic [31:0] rd_addr_r = 32'h0;
    logic [3:0]  rd_type_r = 4'h0;
    logic [7:0]  b0, b1, b2, b3;

    always @(posedge clk) begin
        rd_addr_r <= bus.mem_addr;
        rd_type_r <= bus.mem_load_store_type;
        if (bus.mem_write_enable) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_data[7:0];
            if (bus.mem_load_store_type == T_SH || bus.mem_load_store_type == T_SW)
                mem[bus.mem_addr[9:0] + 10'd1] <= bus.mem_data[15:8];
            if (bus.mem_load_store_type == T_SW) begin
                mem[bus.mem_addr[9:0] + 10'd2] <= bus.mem_data[23:16];
                mem[bus.mem_addr[9:0] + 10'd3] <= bus.mem_data[31:24];
            end
        end
    end

    always_comb begin
        b0 = mem[rd_addr_r[9:0]];
        b1 = mem[rd_addr_r[9:0] + 10'd1];
        b2 = mem[rd_addr_r[9:0] + 10'd2];
        b3 = mem[rd_addr_r[9:0] + 10'd3];
        case (rd_type_r)
            T_LB:    bus.mem_read_data = {{24{b0[7]}}, b0};
            T_LBU:   bus.mem_read_data = {24'h0, b0};
            T_LH:    bus.mem_read_data = {{16{b1[7]}}, b1, b0};
            T_LHU:   bus.mem_read_data = {16'h0, b1, b0};
            T_LW:    bus.mem_read_data = {b3, b2, b1, b0};
            default: bus.mem_read_data = 32'h0;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic resp_t model(input logic [3:0] t, input logic [31:0] b,
                                    input logic [31:0] o, input logic [31:0] d);
        resp_t       r;
        logic [31:0] ea;
        logic [32:0] endp;
        logic [31:0] w;
        logic [1:0]  c;
        int          sz;
        ea = b + o;
        if (t == T_LB || t == T_LBU || t == T_SB)      sz = 1;
        else if (t == T_LH || t == T_LHU || t == T_SH) sz = 2;
        else                                           sz = 4;
        endp = {1'b0, ea} + 33'(sz);
        if (t > T_SW)                                            c = 2'd3;
        else if ((sz == 2 && ea[0]) || (sz == 4 && ea[1:0] != 2'b00)) c = 2'd1;
        else if (endp > 33'(DEPTH))                              c = 2'd2;
        else                                                     c = 2'd0;
        r.addr  = ea;
        r.cause = c;
        r.err   = (c != 2'd0);
        r.data  = 32'h0;
        r.we    = 1'b0;
        if (c != 2'd0) begin
            r.lat = 4'd1;
        end else if (t >= T_SB) begin
            r.lat = 4'd2;
            r.we  = 1'b1;
            for (int i = 0; i < sz; i++) ref_mem[int'(ea) + i] = d[8*i +: 8];
        end else begin
            r.lat = 4'd3;
            w = 32'h0;
            for (int i = 0; i < sz; i++) w[8*i +: 8] = ref_mem[int'(ea) + i];
            if (t == T_LB)      r.data = {{24{w[7]}}, w[7:0]};
            else if (t == T_LH) r.data = {{16{w[15]}}, w[15:0]};
            else                r.data = w;
        end
        return r;
    endfunction

    function automatic string show(input resp_t r);
        return $sformatf("data=%h err=%b cause=%0d addr=%h lat=%0d we=%b",
                         r.data, r.err, r.cause, r.addr, r.lat, r.we);
    endfunction

    // ---------------- drivers ----------------
    task automatic send(input logic [3:0] t, input logic [31:0] b, input logic [31:0] o,
                        input logic [31:0] d, input bit push);
        @(negedge clk);
        bus.req_valid       = 1'b1;
        bus.load_store_type = t;
        bus.base            = b;
        bus.offset          = o;
        bus.store_data      = d;
        if (push) exp_q.push_back(model(t, b, o, d));
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic collect(output resp_t obs, input bit consume);
        bit         got = 1'b0;
        logic [3:0] n = 4'hF;
        logic       we_seen = 1'b0;
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge clk);
            we_seen = we_seen | bus.mem_write_enable;
            if (bus.resp_valid) begin
                got = 1'b1;
                n   = 4'(k);
            end
        end
        obs.data  = bus.resp_data;
        obs.err   = bus.resp_error;
        obs.cause = bus.resp_cause;
        obs.addr  = bus.resp_addr;
        obs.lat   = n;
        obs.we    = we_seen;
        if (consume) begin
            bus.resp_ready = 1'b1;
            @(posedge clk);
            #1 bus.resp_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid, bus.mem_write_enable, bus.resp_error, bus.resp_cause} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy/vld/we/err/cause=%b, expected 100000",
                     {bus.req_ready, bus.resp_valid, bus.mem_write_enable, bus.resp_error, bus.resp_cause});
        end
        n_checks++;
        if ({bus.resp_data, bus.resp_addr, bus.mem_addr, bus.mem_data, bus.mem_load_store_type} !== 132'h0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h addr=%h maddr=%h mdata=%h, expected all zero",
                     bus.resp_data, bus.resp_addr, bus.mem_addr, bus.mem_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got rdy/vld=%b, expected 10", {bus.req_ready, bus.resp_valid});
        end
    endtask

    task automatic run_table(input string name, input req_t tbl[]);
        resp_t obs, exp;
        foreach (tbl[i]) begin
            send(tbl[i].t, tbl[i].b, tbl[i].o, tbl[i].d, 1'b1);
            collect(obs, 1'b1);
            exp = exp_q.pop_front();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s[%0d]: got %s, expected %s", name, i, show(obs), show(exp));
            end
        end
    endtask

    task automatic test_store_load();
        req_t tbl[] = '{
            '{T_SW, 32'h100, 32'h4, 32'hDEADBEEF},
            '{T_LW, 32'h108, 32'hFFFFFFFC, 32'h0}
        };
        run_table("store_load", tbl);
    endtask

    task automatic test_extend();
        req_t tbl[] = '{
            '{T_LB,  32'h104, 32'h0, 32'h0},
            '{T_LBU, 32'h104, 32'h0, 32'h0},
            '{T_LH,  32'h106, 32'h0, 32'h0},
            '{T_LHU, 32'h104, 32'h0, 32'h0},
            '{T_SB,  32'h10B, 32'h0, 32'h777777A5},
            '{T_LBU, 32'h10B, 32'h0, 32'h0},
            '{T_SH,  32'h10C, 32'h0, 32'h55558001},
            '{T_LH,  32'h10C, 32'h0, 32'h0}
        };
        run_table("extend", tbl);
    endtask

    task automatic test_faults();
        req_t tbl[] = '{
            '{T_LW, 32'h102, 32'h0, 32'h0},
            '{T_SH, 32'h101, 32'h0, 32'h12345678},
            '{T_SW, 32'h100, 32'h2, 32'hFFFFFFFF},
            '{T_LW, 32'h104, 32'h0, 32'h0}
        };
        run_table("faults", tbl);
    endtask

    task automatic test_bounds();
        req_t tbl[] = '{
            '{T_LW,  32'(DEPTH - 4), 32'h0, 32'h0},
            '{T_LW,  32'(DEPTH - 2), 32'h0, 32'h0},
            '{T_LB,  32'(DEPTH),     32'h0, 32'h0},
            '{T_BAD, 32'h3,          32'h0, 32'h0},
            '{T_SB,  32'hFFFFFFFF,   32'h1, 32'h0000005A},
            '{T_LBU, 32'hFFFFFFFF,   32'h1, 32'h0},
            '{T_SW,  32'hFFFFFFFC,   32'h0, 32'h11111111},
            '{T_SB,  32'(DEPTH - 1), 32'h0, 32'h000000C3},
            '{T_LB,  32'(DEPTH - 1), 32'h0, 32'h0},
            '{T_LH,  32'(DEPTH),     32'h0, 32'h0}
        };
        run_table("bounds", tbl);
    endtask

    task automatic test_backpressure();
        resp_t obs, exp;
        send(T_LW, 32'h104, 32'h0, 32'h0, 1'b1);
        collect(obs, 1'b0);
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL backpressure_first: got %s, expected %s", show(obs), show(exp));
        end
        bus.req_valid       = 1'b1;
        bus.load_store_type = T_LBU;
        bus.base            = 32'h104;
        bus.offset          = 32'h0;
        bus.store_data      = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.resp_valid, bus.resp_data, bus.resp_error, bus.resp_cause, bus.resp_addr, bus.req_ready} !==
                {1'b1, exp.data, exp.err, exp.cause, exp.addr, 1'b0}) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b data=%h addr=%h rdy=%b, expected vld=1 data=%h addr=%h rdy=0",
                         k, bus.resp_valid, bus.resp_data, bus.resp_addr, bus.req_ready, exp.data, exp.addr);
            end
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        n_checks++;
        if ({bus.req_ready, bus.resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL backpressure_release: got rdy/vld=%b, expected 10", {bus.req_ready, bus.resp_valid});
        end
        exp_q.push_back(model(T_LBU, 32'h104, 32'h0, 32'h0));
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        collect(obs, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL backpressure_pending: got %s, expected %s", show(obs), show(exp));
        end
    endtask

    task automatic test_reset_mid_access();
        resp_t obs, exp;
        send(T_SW, 32'h200, 32'h0, 32'hCAFEF00D, 1'b1);
        collect(obs, 1'b1);
        exp = exp_q.pop_front();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_store_setup: got %s, expected %s", show(obs), show(exp));
        end
        send(T_SW, 32'h200, 32'h0, 32'h12345678, 1'b0);
        n_checks++;
        if (bus.mem_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_store_we: got we=%b, expected 1", bus.mem_write_enable);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_write_enable, bus.req_ready, bus.resp_valid, bus.mem_addr, bus.mem_data, bus.resp_data} !==
            {1'b0, 1'b1, 1'b0, 96'h0}) begin
            n_fail++;
            $display("FAIL reset_store_outputs: got we=%b rdy=%b vld=%b maddr=%h mdata=%h, expected we=0 rdy=1 vld=0 zeros",
                     bus.mem_write_enable, bus.req_ready, bus.resp_valid, bus.mem_addr, bus.mem_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_table("reset_store_readback", '{'{T_LW, 32'h200, 32'h0, 32'h0}});
        send(T_LW, 32'h200, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL reset_load_drop[%0d]: got vld/rdy=%b, expected 01", k, {bus.resp_valid, bus.req_ready});
            end
        end
    endtask

    task automatic test_back_to_back();
        req_t tbl[];
        tbl = new[16];
        foreach (tbl[i]) begin
            tbl[i].t = 4'($urandom_range(0, 9));
            tbl[i].b = 32'h3F0 + 32'($urandom_range(0, 15));
            tbl[i].o = 32'h0;
            tbl[i].d = $urandom;
        end
        run_table("back_to_back", tbl);
    endtask

    initial begin
        bus.req_valid       = 1'b0;
        bus.load_store_type = 4'h0;
        bus.base            = 32'h0;
        bus.offset          = 32'h0;
        bus.store_data      = 32'h0;
        bus.resp_ready      = 1'b0;
        test_reset();
        test_store_load();
        test_extend();
        test_faults();
        test_bounds();
        test_backpressure();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
